// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared encodings for the multicycle MIPS control path:
//   statetype_t  - 4-bit FSM state encoding (FETCH=0 .. BNEEX=12)
//   OP_*         - 6-bit opcodes recognised by the controller
//   ALUOP_*      - 3-bit aluop codes handed to the external ALU decoder
//   ctrl_t       - bundle of every control signal the output decoder produces
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } statetype_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_AND   = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    // Full control vector. pcwrite/branch/bne stay internal to the controller
    // and are folded into pcen at the top level.
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       immext;
        logic       pcwrite;
        logic       branch;
        logic       bne;
    } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// ---------------------------------------------------------------------------
// mc_outdec
// Purely combinational output decoder: maps the current FSM state (and, in
// IMMEX only, the opcode) to the full control vector.
// Ports:
//   state_i  in   statetype_t  state to decode
//   op_i     in   6            opcode, used to pick aluop/immext in IMMEX
//   ctrl_o   out  ctrl_t       decoded control signals
// ---------------------------------------------------------------------------
module mc_outdec
    import mips_pkg::*;
(
    input  statetype_t  state_i,
    input  logic [5:0]  op_i,
    output ctrl_t       ctrl_o
);

    always_comb begin
        // Everything idles at 0; unused encodings fall through to this.
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.irwrite = 1'b1;
                ctrl_o.pcwrite = 1'b1;
                ctrl_o.alusrcb = 2'b01;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            DECODE: begin
                // Precompute the branch target PC+4+(imm<<2) into ALUOut.
                ctrl_o.alusrcb = 2'b11;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = 2'b10;
            end
            MEMRD: begin
                ctrl_o.iord = 1'b1;
            end
            MEMWB: begin
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = 2'b00;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            BEQEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = 2'b01;
                ctrl_o.branch  = 1'b1;
            end
            IMMEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = 2'b10;
                // Logical immediates are zero-extended; arithmetic ones signed.
                case (op_i)
                    OP_ADDI: ctrl_o.aluop = ALUOP_ADD;
                    OP_ORI: begin
                        ctrl_o.aluop  = ALUOP_OR;
                        ctrl_o.immext = 1'b1;
                    end
                    OP_ANDI: begin
                        ctrl_o.aluop  = ALUOP_AND;
                        ctrl_o.immext = 1'b1;
                    end
                    OP_SLTI: ctrl_o.aluop = ALUOP_SLT;
                    default: ctrl_o.aluop = ALUOP_ADD;
                endcase
            end
            IMMWB: begin
                ctrl_o.regwrite = 1'b1;
            end
            JEX: begin
                ctrl_o.pcsrc   = 2'b10;
                ctrl_o.pcwrite = 1'b1;
            end
            BNEEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = 2'b01;
                ctrl_o.bne     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
// Moore control FSM for a shared-memory multicycle MIPS datapath. Owns the
// state register and next-state logic, and combines pcwrite/branch/bne with
// the ALU zero flag into the single PC enable.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   op[5:0], zero              opcode from IR, ALU zero flag
//   iord, memwrite, irwrite,   memory / IR controls
//   regdst, memtoreg, regwrite register-file controls
//   alusrca, alusrcb[1:0],     ALU operand selects
//   aluop[2:0], immext         ALU operation class, immediate extension
//   pcsrc[1:0], pcen           PC source select and PC enable
//   state_o[3:0]               current state (0 while reset is high)
// ---------------------------------------------------------------------------
module mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       immext,
    output logic       pcen,
    output logic [3:0] state_o
);

    statetype_t state_q;
    statetype_t state_d;
    statetype_t dec_state;
    ctrl_t      ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW:                      state_d = MEMADR;
                    OP_RTYPE:                          state_d = RTYPEEX;
                    OP_BEQ:                            state_d = BEQEX;
                    OP_BNE:                            state_d = BNEEX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = IMMEX;
                    OP_J:                              state_d = JEX;
                    default:                           state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW) begin
                    state_d = MEMRD;
                end else if (op == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            IMMEX:   state_d = IMMWB;
            default: state_d = FETCH;
        endcase
    end

    // The state register only changes on the next edge, so during a reset
    // cycle the outputs are decoded as if already in FETCH.
    assign dec_state = reset ? FETCH : state_q;

    mc_outdec u_outdec (
        .state_i (dec_state),
        .op_i    (op),
        .ctrl_o  (ctrl)
    );

    assign iord     = ctrl.iord;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign aluop    = ctrl.aluop;
    assign immext   = ctrl.immext;

    // Write enables are suppressed while reset is held so an aborted
    // instruction cannot commit anything.
    assign memwrite = ctrl.memwrite & ~reset;
    assign irwrite  = ctrl.irwrite  & ~reset;
    assign regwrite = ctrl.regwrite & ~reset;
    assign pcen     = ~reset & (ctrl.pcwrite
                              | (ctrl.branch & zero)
                              | (ctrl.bne & ~zero));

    assign state_o  = reset ? 4'd0 : 4'(state_q);

endmodule
